dfconv_sched: RTL and testbench

Parametrised, queued successor to the deformable-convolution cycle-cost model. It accepts conv jobs through a valid/ready port into a small job FIFO. For each job it computes an interpolation-plus-MAC cycle budget, with kernel size and MAC-reduction mode selectable per job, and then occupies the engine for exactly that many cycles in two visible phases. It reports each completion with a tag and cycle count, and it sits in the accelerator performance model alongside the other cost-model blocks.

---
 rtl/dfconv_pkg.sv | 43 ++++
 rtl/dfconv_if.sv | 40 ++++
 rtl/dfconv_job_fifo.sv | 55 +++++
 rtl/dfconv_sched.sv | 192 +++++++++++++++++++
 tb/tb_dfconv_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfconv_pkg.sv
// dfconv_sched shared types: FSM states, phase codes,
// MAC-reduction modes and cost-arithmetic width helpers.
package dfconv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_INTERP,
    S_MAC,
    S_FIN
  } state_t;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_INTERP = 2'd1;
  localparam logic [1:0] PH_MAC    = 2'd2;

  typedef enum logic [1:0] {
    MODE_D1  = 2'd0,
    MODE_D2  = 2'd1,
    MODE_D4  = 2'd2,
    MODE_D4X = 2'd3
  } mode_t;

  function automatic logic [1:0] mode_shift(
    input mode_t m
  );
    logic [1:0] s;
    unique case (m)
      MODE_D1: s = 2'd0;
      MODE_D2: s = 2'd1;
      default: s = 2'd2;
    endcase
    return s;
  endfunction

  // rows*cols*in_ch*out_ch plus K^2 (K<=7)
  function automatic int prod_w(input int w);
    return 4 * w + 6;
  endfunction

  localparam int PROD_W = prod_w(16);

endpackage

// File: rtl/dfconv_if.sv
// Job submission port of dfconv_sched:
// valid/ready handshake plus the job descriptor.
interface dfconv_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             job_valid;
  logic             job_ready;
  logic [WIDTH-1:0] rows;
  logic [WIDTH-1:0] cols;
  logic [WIDTH-1:0] in_ch;
  logic [WIDTH-1:0] out_ch;
  logic [2:0]       ksize;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag;

  modport master (
    output job_valid,
    output rows,
    output cols,
    output in_ch,
    output out_ch,
    output ksize,
    output mode,
    output tag,
    input  job_ready
  );

  modport slave (
    input  job_valid,
    input  rows,
    input  cols,
    input  in_ch,
    input  out_ch,
    input  ksize,
    input  mode,
    input  tag,
    output job_ready
  );
endinterface

// File: rtl/dfconv_job_fifo.sv
// Synchronous job FIFO with flush; read data is
// the head entry, valid whenever empty is low.
module dfconv_job_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= wdata;
  end

  assign rdata = mem[rp];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/dfconv_sched.sv
// Queued deformable-conv cycle-cost scheduler:
// per-job interp+MAC budget, run in two phases.
module dfconv_sched
  import dfconv_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int INTERP_COST = 2,
  parameter int PE_COUNT    = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dfconv_if.slave              job,
  input  logic                 abort,
  output logic                 busy,
  output logic [1:0]           phase,
  output logic                 done,
  output logic [TAG_W-1:0]     done_tag,
  output logic [ACC_WIDTH-1:0] cycles_used,
  output logic                 aborted,
  output logic [ACC_WIDTH-1:0] total_cycles
);

  localparam int PW = prod_w(WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  typedef struct packed {
    logic [WIDTH-1:0] rows;
    logic [WIDTH-1:0] cols;
    logic [WIDTH-1:0] in_ch;
    logic [WIDTH-1:0] out_ch;
    logic [2:0]       ksize;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
  } job_t;

  localparam int JW = $bits(job_t);

  job_t           wr_job;
  job_t           rd_job;
  job_t           cur;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [CW-1:0]  fcnt;
  state_t         state;
  state_t         state_n;

  logic [ACC_WIDTH-1:0] i_q;
  logic [ACC_WIDTH-1:0] t_q;
  logic [ACC_WIDTH-1:0] run_cnt;
  logic [ACC_WIDTH-1:0] i_calc;
  logic [ACC_WIDTH-1:0] t_calc;
  logic [ACC_WIDTH-1:0] t_now;
  logic [ACC_WIDTH:0]   sum;

  logic [PW-1:0] p;
  logic [PW-1:0] k;
  logic [PW-1:0] prod;
  logic [PW-1:0] m;
  logic [PW-1:0] c;
  logic [PW-1:0] ii;
  logic [PW-1:0] tt;

  assign wr_job = '{
    rows:   job.rows,
    cols:   job.cols,
    in_ch:  job.in_ch,
    out_ch: job.out_ch,
    ksize:  job.ksize,
    mode:   job.mode,
    tag:    job.tag
  };

  // ready follows registered occupancy, so a pop
  // while full does not reopen it that cycle
  assign job.job_ready = !full && !abort;
  assign push = job.job_valid && job.job_ready;
  assign pop  = (state == S_IDLE) && !empty && !abort;

  dfconv_job_fifo #(
    .DW    (JW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (wr_job),
    .rdata (rd_job),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  always_comb begin
    k    = (cur.ksize == 3'd0) ? PW'(1) : PW'(cur.ksize);
    p    = PW'(cur.rows) * PW'(cur.cols);
    ii   = p * PW'(INTERP_COST);
    prod = p * PW'(cur.out_ch) * (k * k) * PW'(cur.in_ch);
    m    = prod >> mode_shift(mode_t'(cur.mode));
    c    = m / PW'(PE_COUNT)
         + PW'((m % PW'(PE_COUNT)) != '0);
    tt   = ii + c;
    t_calc = (tt > PW'(ACC_MAX)) ?
             ACC_MAX : tt[ACC_WIDTH-1:0];
    // a saturated budget caps the interp phase too
    i_calc = (ii > PW'(t_calc)) ?
             t_calc : ii[ACC_WIDTH-1:0];
  end

  assign t_now = (state == S_CALC) ? t_calc : t_q;
  assign sum   = {1'b0, total_cycles} + {1'b0, t_now};

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (pop) state_n = S_CALC;
      end
      S_CALC: begin
        unique case (1'b1)
          (t_calc == '0): state_n = S_FIN;
          (i_calc != '0): state_n = S_INTERP;
          default:        state_n = S_MAC;
        endcase
      end
      S_INTERP: begin
        if (run_cnt == i_q)
          state_n = (t_q > i_q) ? S_MAC : S_FIN;
      end
      S_MAC: begin
        if (run_cnt == t_q) state_n = S_FIN;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur          <= '0;
      i_q          <= '0;
      t_q          <= '0;
      run_cnt      <= '0;
      done         <= 1'b0;
      done_tag     <= '0;
      cycles_used  <= '0;
      total_cycles <= '0;
      aborted      <= 1'b0;
    end else begin
      state   <= state_n;
      done    <= (state_n == S_FIN);
      aborted <= abort &&
        ((state inside {S_CALC, S_INTERP, S_MAC}) ||
         !empty);
      if (pop) cur <= rd_job;
      if (state == S_CALC) begin
        i_q     <= i_calc;
        t_q     <= t_calc;
        run_cnt <= ACC_WIDTH'(1);
      end else if (state inside {S_INTERP, S_MAC}) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (state_n == S_FIN) begin
        done_tag     <= cur.tag;
        cycles_used  <= t_now;
        total_cycles <= sum[ACC_WIDTH] ?
                        ACC_MAX : sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    phase = PH_IDLE;
    unique case (state)
      S_INTERP: phase = PH_INTERP;
      S_MAC:    phase = PH_MAC;
      default:  phase = PH_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) || (fcnt != '0);

endmodule

// File: tb/tb_dfconv_sched.sv
// Randomised + directed bench for dfconv_sched with a
// job-level timing/cost model and per-cycle compare.
module tb_dfconv_sched;

  localparam int AW    = 14;
  localparam int W     = 16;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam longint TMAX = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic [1:0]    phase;
  logic          done;
  logic [TW-1:0] done_tag;
  logic [AW-1:0] cycles_used;
  logic          aborted;
  logic [AW-1:0] total_cycles;

  dfconv_if #(.WIDTH(W), .TAG_W(TW)) jif();

  dfconv_sched #(
    .WIDTH       (W),
    .ACC_WIDTH   (AW),
    .INTERP_COST (2),
    .PE_COUNT    (64),
    .FIFO_DEPTH  (DEPTH),
    .TAG_W       (TW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job          (jif),
    .abort        (abort),
    .busy         (busy),
    .phase        (phase),
    .done         (done),
    .done_tag     (done_tag),
    .cycles_used  (cycles_used),
    .aborted      (aborted),
    .total_cycles (total_cycles)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     tag;
    longint t;
    longint i;
    longint e;
    longint a;
  } ent_t;

  ent_t   q[$];
  longint last_done = -10;
  longint exp_sum = 0;
  longint exp_cu = 0;
  longint acc_sum = 0;
  int     exp_tag = 0;
  bit     exp_ab = 0;
  bit     chk_en = 0;
  int     ncmp = 0;
  int     nbad = 0;
  int     pin_c[16];
  int     pin_lat[16];
  int     pin_p1[16];
  int     pin_p2[16];
  int     p1_cnt = 0;
  int     p2_cnt = 0;

  bit     acc_p, ab_p, rs_p;
  int     pj_tag;
  longint pj_t, pj_i;

  task automatic chk(string nm, longint act, longint exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d",
               nm, cyc, act, exp);
    end
  endtask

  function automatic void cost(
    input longint r, c, ic, oc, k, md,
    output longint t, output longint i);
    logic [127:0] p, m, ii, cc, tt;
    longint kk;
    longint dv;
    kk = (k == 0) ? 1 : k;
    dv = (md == 0) ? 1 : (md == 1) ? 2 : 4;
    p  = 128'(r) * 128'(c);
    ii = p * 128'(2);
    m  = (p * 128'(oc) * 128'(ic) * 128'(kk * kk))
         / 128'(dv);
    cc = m / 128'(64) + ((m % 128'(64)) != 0 ? 128'(1) : 128'(0));
    tt = ii + cc;
    if (tt > 128'(TMAX)) tt = 128'(TMAX);
    if (ii > tt) ii = tt;
    t = longint'(tt);
    i = longint'(ii);
  endfunction

  // apply what the DUT saw at the edge just passed
  task automatic proc();
    ent_t en;
    longint prev;
    if (rs_p) begin
      q.delete();
      exp_sum = 0; exp_cu = 0; exp_tag = 0; exp_ab = 0;
      last_done = cyc - 1; p1_cnt = 0; p2_cnt = 0;
    end else if (ab_p) begin
      exp_ab = (q.size() > 0);
      q.delete();
      last_done = cyc - 1; p1_cnt = 0; p2_cnt = 0;
    end else begin
      exp_ab = 0;
      if (acc_p) begin
        prev = (q.size() > 0) ?
               q[$].e + q[$].t + 1 : last_done;
        en.tag = pj_tag; en.t = pj_t; en.i = pj_i;
        en.a = cyc;
        en.e = (cyc + 1 > prev + 2) ? cyc + 1 : prev + 2;
        q.push_back(en);
        acc_sum += pj_t;
      end
    end
  endtask

  task automatic cycle();
    #1;
    acc_p = jif.job_valid && jif.job_ready && rst_n;
    ab_p = abort;
    rs_p = !rst_n;
    pj_tag = int'(jif.tag);
    cost(jif.rows, jif.cols, jif.in_ch, jif.out_ch,
         jif.ksize, jif.mode, pj_t, pj_i);
    @(posedge clk);
    #1;
    proc();
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) cycle();
  endtask

  task automatic offer(int r, int c, int ic, int oc,
                       int k, int md, int tg);
    int n;
    n = 0;
    jif.job_valid = 1'b1;
    jif.rows = W'(r); jif.cols = W'(c);
    jif.in_ch = W'(ic); jif.out_ch = W'(oc);
    jif.ksize = 3'(k); jif.mode = 2'(md);
    jif.tag = TW'(tg);
    do begin
      cycle();
      n++;
    end while (!acc_p && n < 30000);
    jif.job_valid = 1'b0;
    if (!acc_p) chk("offer_timeout", 0, 1);
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while (q.size() > 0 && n < maxc) begin
      cycle();
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    int ph;
    bit de;
    int fc;
    int tg;
    if (chk_en) begin
      ph = 0; de = 0; fc = 0;
      if (q.size() > 0) begin
        if (cyc >= q[0].e + 1 && cyc <= q[0].e + q[0].i)
          ph = 1;
        else if (cyc > q[0].e + q[0].i && cyc <= q[0].e + q[0].t)
          ph = 2;
        de = (cyc == q[0].e + q[0].t + 1);
      end
      foreach (q[j]) if (q[j].e > cyc) fc++;
      chk("busy", busy, q.size() > 0);
      chk("phase", phase, ph);
      chk("job_ready", jif.job_ready, fc < DEPTH && !abort);
      chk("aborted", aborted, exp_ab);
      chk("done", done, de);
      if (phase == 2'd1) p1_cnt++;
      if (phase == 2'd2) p2_cnt++;
      if (de) begin
        tg = q[0].tag;
        exp_tag = tg;
        exp_cu = q[0].t;
        exp_sum = (exp_sum + q[0].t > TMAX) ?
                  TMAX : exp_sum + q[0].t;
        if (pin_c[tg] >= 0)
          chk("pin_cycles", cycles_used, pin_c[tg]);
        if (pin_lat[tg] >= 0)
          chk("pin_latency", cyc - q[0].a, pin_lat[tg]);
        if (pin_p1[tg] >= 0)
          chk("pin_interp_len", p1_cnt, pin_p1[tg]);
        if (pin_p2[tg] >= 0)
          chk("pin_mac_len", p2_cnt, pin_p2[tg]);
        pin_c[tg] = -1; pin_lat[tg] = -1;
        pin_p1[tg] = -1; pin_p2[tg] = -1;
        p1_cnt = 0; p2_cnt = 0;
        last_done = cyc;
        void'(q.pop_front());
      end
      chk("done_tag", done_tag, exp_tag);
      chk("cycles_used", cycles_used, exp_cu);
      chk("total_cycles", total_cycles, exp_sum);
    end
  end

  initial begin
    longint six_base;
    for (int j = 0; j < 16; j++) begin
      pin_c[j] = -1; pin_lat[j] = -1;
      pin_p1[j] = -1; pin_p2[j] = -1;
    end
    jif.job_valid = 1'b0;
    jif.rows = '0; jif.cols = '0;
    jif.in_ch = '0; jif.out_ch = '0;
    jif.ksize = '0; jif.mode = '0; jif.tag = '0;

    cycle();
    cycle();
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_ready", jif.job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_total", total_cycles, 0);

    // directed budgets
    pin_c[1] = 761; pin_lat[1] = 763;
    offer(4, 4, 36, 36, 3, 2, 1);
    drain(5000);
    pin_c[2] = 3044;
    offer(8, 8, 36, 36, 3, 2, 2);
    drain(5000);
    pin_c[3] = 408; pin_p1[3] = 8; pin_p2[3] = 400;
    offer(2, 2, 16, 16, 5, 0, 3);
    drain(5000);
    pin_c[4] = 3;
    offer(1, 1, 1, 1, 3, 2, 4);
    drain(100);
    pin_c[5] = 0; pin_lat[5] = 2;
    offer(0, 5, 7, 9, 3, 1, 5);
    drain(100);
    chk("directed_total", total_cycles, 4216);

    // six back-to-back jobs behind a long one
    acc_sum = 0;
    offer(4, 4, 36, 36, 3, 2, 1);
    for (int tg = 2; tg <= 5; tg++)
      offer($urandom_range(4, 1), $urandom_range(4, 1),
            $urandom_range(8, 1), $urandom_range(8, 1),
            $urandom_range(7, 0), $urandom_range(3, 0), tg);
    jif.job_valid = 1'b1;
    #1;
    chk("full_ready", jif.job_ready, 0);
    offer(3, 2, 5, 7, 3, 1, 6);
    drain(20000);
    chk("six_total", total_cycles, 4216 + acc_sum);

    // abort during MAC with two jobs queued
    offer(2, 2, 16, 16, 5, 0, 7);
    offer(1, 2, 3, 4, 3, 0, 8);
    offer(2, 1, 4, 3, 2, 1, 9);
    begin
      int n;
      n = 0;
      while (phase != 2'd2 && n < 2000) begin
        cycle();
        n++;
      end
      if (phase != 2'd2) chk("mac_wait_timeout", 0, 1);
    end
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    #1;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    cycle();
    chk("abort_once", aborted, 0);
    pin_c[10] = 3;
    offer(1, 1, 1, 1, 3, 2, 10);
    drain(100);

    // randomised traffic with occasional aborts
    for (int j = 0; j < 30; j++) begin
      idle($urandom_range(3, 0));
      if ($urandom_range(24, 0) == 0) begin
        abort = 1'b1;
        cycle();
        abort = 1'b0;
      end
      offer($urandom_range(4, 0), $urandom_range(4, 1),
            $urandom_range(8, 1), $urandom_range(8, 1),
            $urandom_range(7, 0), $urandom_range(3, 0),
            $urandom_range(15, 0));
    end
    drain(40000);

    // saturating budget and saturating total
    pin_c[11] = 16383;
    offer(65535, 65535, 65535, 65535, 7, 0, 11);
    drain(20000);
    chk("sat_total", total_cycles, 16383);

    // reset in the middle of a run
    offer(65535, 65535, 65535, 65535, 7, 0, 12);
    idle(50);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", jif.job_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_phase", phase, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_tag", done_tag, 0);
    chk("mid_rst_cycles", cycles_used, 0);
    chk("mid_rst_aborted", aborted, 0);
    chk("mid_rst_total", total_cycles, 0);
    idle(3);
    pin_c[13] = 408;
    offer(2, 2, 16, 16, 5, 0, 13);
    drain(2000);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
